// File: rtl/mac_engine_pkg.sv
// mac_engine_pkg
//   Shared defaults and types for the binary-weight MAC engine.
//   N_IN   : number of activation rows
//   N_OUT  : number of output columns
//   ACT_W  : unsigned activation width
//   OUT_W  : unsigned quantized result width
//   SHIFT  : right shift applied to each column sum before saturation
//   ACC_W  : signed accumulator width. It holds +/- N_IN * (2^ACT_W - 1)
//            with no overflow.
package mac_engine_pkg;

  localparam int unsigned N_IN  = 8;
  localparam int unsigned N_OUT = 8;
  localparam int unsigned ACT_W = 4;
  localparam int unsigned OUT_W = 4;
  localparam int unsigned SHIFT = 3;
  localparam int unsigned ACC_W = ACT_W + $clog2(N_IN) + 1;

  typedef logic [N_IN-1:0][ACT_W-1:0] act_vec_t;
  typedef logic [N_IN-1:0][N_OUT-1:0] w_mat_t;
  typedef logic [N_OUT-1:0][OUT_W-1:0] res_vec_t;

endpackage

// File: rtl/mac_engine_column.sv
// mac_column
//   Combinational datapath for one output column.
//   It forms the signed sum of +/-act_i[i], where weight bit 1 means +1 and
//   weight bit 0 means -1. It then floor-shifts the sum right by SHIFT and
//   clamps the result to the range [0, 2^OUT_W - 1].
// Ports
//   act_i   : packed activations, unsigned, zero-extended before summing
//   w_col_i : one weight column; w_col_i[i] applies to act_i[i]
//   q_o     : quantized column result (combinational)
module mac_column
  import mac_engine_pkg::*;
#(
  parameter int unsigned N_IN  = mac_engine_pkg::N_IN,
  parameter int unsigned ACT_W = mac_engine_pkg::ACT_W,
  parameter int unsigned OUT_W = mac_engine_pkg::OUT_W,
  parameter int unsigned SHIFT = mac_engine_pkg::SHIFT,
  parameter int unsigned ACC_W = ACT_W + $clog2(N_IN) + 1
) (
  input  logic [N_IN-1:0][ACT_W-1:0] act_i,
  input  logic [N_IN-1:0]            w_col_i,
  output logic [OUT_W-1:0]           q_o
);

  localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'((1 << OUT_W) - 1);

  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] term_d;
  logic signed [ACC_W-1:0] shifted_d;

  always_comb begin
    acc_d  = '0;
    term_d = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      term_d = $signed({{(ACC_W-ACT_W){1'b0}}, act_i[i]});
      if (w_col_i[i]) acc_d = acc_d + term_d;
      else            acc_d = acc_d - term_d;
    end
  end

  // An arithmetic shift of a non-negative value is a floor divide by 2^SHIFT.
  // Negative sums are forced to zero before the shift result matters.
  always_comb begin
    shifted_d = acc_d >>> SHIFT;
    q_o       = '0;
    if (acc_d < 0)              q_o = '0;
    else if (shifted_d > Q_MAX) q_o = '1;
    else                        q_o = shifted_d[OUT_W-1:0];
  end

endmodule

// File: rtl/mac_engine.sv
// mac_engine
//   Binary-weight matrix-vector MAC with per-column requantization.
//   All N_OUT columns are computed in parallel from the same activation
//   vector. The results are registered, so latency is one clock and
//   throughput is one vector per clock.
// Ports
//   clk   : clock; all state updates occur on its rising edge
//   nrst  : synchronous reset, active-high, clears every result
//   act_i : packed activations; act_i[i] is activation i
//   w_i   : binary weights; w_i[i][k] links activation i to column k
//   res_o : registered quantized results; res_o[k] is column k
module mac_engine
  import mac_engine_pkg::*;
#(
  parameter int unsigned N_IN  = mac_engine_pkg::N_IN,
  parameter int unsigned N_OUT = mac_engine_pkg::N_OUT,
  parameter int unsigned ACT_W = mac_engine_pkg::ACT_W,
  parameter int unsigned OUT_W = mac_engine_pkg::OUT_W,
  parameter int unsigned SHIFT = mac_engine_pkg::SHIFT
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic [N_IN-1:0][ACT_W-1:0]  act_i,
  input  logic [N_IN-1:0][N_OUT-1:0]  w_i,
  output logic [N_OUT-1:0][OUT_W-1:0] res_o
);

  localparam int unsigned ACC_W_L = ACT_W + $clog2(N_IN) + 1;

  logic [N_OUT-1:0][OUT_W-1:0] res_d;
  logic [N_OUT-1:0][OUT_W-1:0] res_q;

  for (genvar k = 0; k < N_OUT; k++) begin : g_col
    logic [N_IN-1:0] w_col;

    // Gather column k from the row-major weight matrix.
    always_comb begin
      w_col = '0;
      for (int unsigned i = 0; i < N_IN; i++) begin
        w_col[i] = w_i[i][k];
      end
    end

    mac_column #(
      .N_IN  (N_IN),
      .ACT_W (ACT_W),
      .OUT_W (OUT_W),
      .SHIFT (SHIFT),
      .ACC_W (ACC_W_L)
    ) u_col (
      .act_i   (act_i),
      .w_col_i (w_col),
      .q_o     (res_d[k])
    );
  end

  always_ff @(posedge clk) begin
    if (nrst) res_q <= '0;
    else      res_q <= res_d;
  end

  assign res_o = res_q;

endmodule

// File: tb/tb_mac_engine.sv
module tb_mac_engine;
  import mac_engine_pkg::*;

  logic     clk;
  logic     nrst;
  act_vec_t act;
  w_mat_t   w;
  res_vec_t res;

  int checks;
  int errors;

  res_vec_t exp_q;
  bit       exp_valid;

  mac_engine #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT),
    .ACT_W (ACT_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) dut (
    .clk   (clk),
    .nrst  (nrst),
    .act_i (act),
    .w_i   (w),
    .res_o (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: integer column sums, floor divide, then clamp.
  function automatic res_vec_t model(input act_vec_t a, input w_mat_t wm);
    res_vec_t r;
    int s;
    int q;
    int qmax;
    qmax = (1 << OUT_W) - 1;
    r = '0;
    for (int k = 0; k < N_OUT; k++) begin
      s = 0;
      for (int i = 0; i < N_IN; i++) begin
        if (wm[i][k]) s = s + int'(a[i]);
        else          s = s - int'(a[i]);
      end
      if (s < 0) q = 0;
      else begin
        q = s / (1 << SHIFT);
        if (q > qmax) q = qmax;
      end
      r[k] = OUT_W'(q);
    end
    return r;
  endfunction

  task automatic chk(input string name, input res_vec_t actual, input res_vec_t expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Expected register contents, updated at each rising edge.
  always @(posedge clk) begin
    exp_q     <= nrst ? res_vec_t'('0) : model(act, w);
    exp_valid <= 1'b1;
  end

  always @(negedge clk) begin
    if (exp_valid) chk("stream", res, exp_q);
  end

  // Apply one vector, pass one rising edge, and return 1 ns after that edge.
  task automatic step(input act_vec_t a, input w_mat_t wm, input logic r);
    act  = a;
    w    = wm;
    nrst = r;
    @(posedge clk);
    #1;
  endtask

  // Apply a vector, then check both the DUT output and the model
  // against a hand-computed value.
  task automatic directed(input string name, input act_vec_t a, input w_mat_t wm,
                          input res_vec_t lit);
    chk({name, "_model"}, model(a, wm), lit);
    step(a, wm, 1'b0);
    chk(name, res, lit);
  endtask

  function automatic act_vec_t all_act(input logic [ACT_W-1:0] v);
    act_vec_t a;
    for (int i = 0; i < N_IN; i++) a[i] = v;
    return a;
  endfunction

  function automatic res_vec_t all_res(input logic [OUT_W-1:0] v);
    res_vec_t r;
    for (int k = 0; k < N_OUT; k++) r[k] = v;
    return r;
  endfunction

  function automatic w_mat_t rows_pos(input int n);
    w_mat_t m;
    m = '0;
    for (int i = 0; i < N_IN; i++) if (i < n) m[i] = '1;
    return m;
  endfunction

  initial begin
    act_vec_t a;
    w_mat_t   wm;
    res_vec_t r;
    checks    = 0;
    errors    = 0;
    exp_valid = 1'b0;
    exp_q     = '0;
    act       = '0;
    w         = '0;
    nrst      = 1'b1;

    // Reset with random inputs: outputs stay zero on every reset edge.
    for (int c = 0; c < 5; c++) begin
      step(act_vec_t'($urandom()), {$urandom(), $urandom()}, 1'b1);
      chk("reset", res, '0);
    end

    directed("full_pos", all_act(4'd15), '1, all_res(4'd15));
    directed("full_neg", all_act(4'd15), '0, all_res(4'd0));
    directed("mixed_5", all_act(4'd15), rows_pos(5), all_res(4'd3));
    directed("mixed_4", all_act(4'd15), rows_pos(4), all_res(4'd0));

    for (int i = 0; i < N_IN; i++) wm[i] = 8'h55;
    r = '0;
    for (int k = 0; k < N_OUT; k += 2) r[k] = 4'd8;
    directed("col_indep", all_act(4'd8), wm, r);

    // Boundaries: only activation 0 is non-zero, with a positive weight.
    a = '0; a[0] = 4'd7;
    directed("below_step", a, '1, all_res(4'd0));
    a[0] = 4'd8;
    directed("one_step", a, '1, all_res(4'd1));
    a = all_act(4'd15); a[3] = 4'd14;
    directed("acc_119", a, '1, all_res(4'd14));

    // Random stream with a single-cycle reset pulse in the middle.
    for (int n = 0; n < 50; n++) begin
      if (n == 25) begin
        step(act_vec_t'($urandom()), {$urandom(), $urandom()}, 1'b1);
        chk("mid_reset", res, '0);
      end
      step(act_vec_t'($urandom()), {$urandom(), $urandom()}, 1'b0);
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_engine.md
MAC_ENGINE -- requirements
Module: mac_engine

Interface
REQ-001 Parameter: N_IN, 8, number of activation inputs (rows).
REQ-002 Parameter: N_OUT, 8, number of output columns.
REQ-003 Parameter: ACT_W, 4, activation width, unsigned.
REQ-004 Parameter: OUT_W, 4, result width, unsigned.
REQ-005 Parameter: SHIFT, 3, right-shift applied to each column sum before saturation.
REQ-006 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-007 Port: nrst  input  1  reset; synchronous, active-high (1 = reset).
REQ-008 Port: act_i  input  [N_IN-1:0][ACT_W-1:0]  packed activations; act_i[i] is activation i.
REQ-009 Port: w_i  input  [N_IN-1:0][N_OUT-1:0]  binary weights; w_i[i][k] connects activation i to column k.
REQ-010 Port: res_o  output  [N_OUT-1:0][OUT_W-1:0]  registered quantized column results; res_o[k] is column k.
REQ-011 There is one clock; reset is synchronous and active-high.

Function
REQ-012 Weight encoding: w_i[i][k]=1 means +1, w_i[i][k]=0 means -1.
REQ-013 Column sum: acc_k = sum over i of (+act_i[i] if w_i[i][k] else -act_i[i]); acts are zero-extended.
REQ-014 acc_k is a signed value of at least 8 bits (range -120..+120 at defaults), with no overflow for any input.
REQ-015 Requantization: q_k = 0 if acc_k < 0; otherwise q_k = min(acc_k >>> SHIFT, 2^OUT_W - 1).
REQ-016 The shift uses floor semantics, with no rounding.
REQ-017 Latency: res_o[k] is the q_k of act_i/w_i sampled at rising edge t, and appears after edge t.
REQ-018 Throughput is one new input vector per cycle, with no stall and no handshake.
REQ-019 All N_OUT columns are computed in parallel from the same act_i.
REQ-020 Boundary: acc_k = 0 gives 0; a positive acc_k smaller than 2^SHIFT gives 0; acc_k above 15<<SHIFT saturates to 15.
REQ-021 X/undriven inputs are not specially handled; outputs are defined only for defined inputs.

Reset
REQ-022 When nrst=1 at a rising edge, every res_o[k] becomes 0 on that edge.
REQ-023 Reset has priority over the data update.
REQ-024 Reset asserted mid-stream discards the in-flight result.
REQ-025 The first valid result appears one edge after the first non-reset edge.
REQ-026 The block holds no other state.

Structure
REQ-027 Shared package mac_engine_pkg holds N_IN, N_OUT, ACT_W, OUT_W and SHIFT defaults, plus the accumulator width constant ACC_W = ACT_W + clog2(N_IN) + 1.
REQ-028 The package also holds typedefs act_vec_t, w_mat_t and res_vec_t.
REQ-029 One sub-module, mac_column, computes one column: its inputs are act_i and one weight column; its output is combinational q_k.
REQ-030 mac_engine instantiates N_OUT mac_column copies via generate, followed by the output register bank.

Verification
REQ-031 Reset: nrst=1 for 5 cycles with random inputs -> res_o = all zeros on every one of those cycles.
REQ-032 Full positive: all act_i=15, all w_i=1 -> next cycle every res_o[k]=15 (acc=120, 120>>>3=15).
REQ-033 Full negative: all act_i=15, all w_i=0 -> next cycle every res_o[k]=0 (acc=-120, clamped).
REQ-034 Mixed rows: all act_i=15; for each k, w_i[i][k]=1 for i<5, 0 otherwise -> acc=30 -> every res_o[k]=3. Same with i<4 -> acc=0 -> res_o=0.
REQ-035 Column independence: all act_i=8; w_i[i][k]=1 for all i when k is even, 0 when k is odd -> even columns 8 (64>>>3), odd columns 0.
REQ-036 Streaming plus mid-stream reset: 50 consecutive random vectors compared against a golden model with exact 1-cycle latency and zero mismatches. nrst pulsed for 1 cycle mid-stream -> res_o=0 for that edge, then results resume one cycle later.
